// File: rtl/cpu_types_pkg.sv
// Shared types and default constants for the program-counter slice.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } pc_state_t;

  localparam word_t PC_RESET_DEFAULT   = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEFAULT = 32'h8000_0180;
  localparam int    PC_STEP_DEFAULT    = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of fetch-control inputs and PC outputs between the core and pc_unit.
// Latency: n/a (wires only).
// Backpressure: ihit/stall from the core hold the PC; no backpressure into the core.
// Modports: pc (the PC unit), tb (whoever drives the core side).
// Optional macro PC_RAS_EN adds ras_push, ras_pop and ras_top.
interface pc_unit_if #(
  parameter int WORD_W = 32
);

  logic              ihit;
  logic              stall;
  logic              redir_valid;
  logic [WORD_W-1:0] redir_target;
  logic              exc_req;
  logic [WORD_W-1:0] exc_pc;
  logic              eret;
  logic              halt;
  logic [WORD_W-1:0] pc_out;
  logic [WORD_W-1:0] pc_next;
  logic [WORD_W-1:0] epc_out;
  logic              halted;
  logic              misalign;
`ifdef PC_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic [WORD_W-1:0] ras_top;
`endif

  modport pc (
`ifdef PC_RAS_EN
    input  ras_push,
    input  ras_pop,
    output ras_top,
`endif
    input  ihit,
    input  stall,
    input  redir_valid,
    input  redir_target,
    input  exc_req,
    input  exc_pc,
    input  eret,
    input  halt,
    output pc_out,
    output pc_next,
    output epc_out,
    output halted,
    output misalign
  );

  modport tb (
`ifdef PC_RAS_EN
    output ras_push,
    output ras_pop,
    input  ras_top,
`endif
    output ihit,
    output stall,
    output redir_valid,
    output redir_target,
    output exc_req,
    output exc_pc,
    output eret,
    output halt,
    input  pc_out,
    input  pc_next,
    input  epc_out,
    input  halted,
    input  misalign
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; overflow overwrites the oldest entry.
// Latency: push/pop visible on top one cycle after the edge; top is a mux of the array.
// Backpressure: none; updates only when en is high (RUN and not stalled).
// Ports: clk, rst (sync, active-high), en, push, pop, push_dat in; top out.
module pc_ras #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] push_dat,
  output logic [WORD_W-1:0] top
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  ptr_q;   // index of the current top entry
  logic [CNT_W-1:0]  cnt_q;   // valid entries, saturates at DEPTH
  logic [PTR_W-1:0]  ptr_inc;
  logic [PTR_W-1:0]  ptr_dec;

  // Explicit wrap so non-power-of-two depths still behave circularly.
  assign ptr_inc = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en) begin
      if (push && pop) begin
        // Replace the top; on an empty stack this behaves as a plain push.
        if (cnt_q == '0) begin
          mem[ptr_inc] <= push_dat;
          ptr_q        <= ptr_inc;
          cnt_q        <= CNT_W'(1);
        end else begin
          mem[ptr_q] <= push_dat;
        end
      end else if (push) begin
        mem[ptr_inc] <= push_dat;
        ptr_q        <= ptr_inc;
        if (cnt_q != CNT_W'(DEPTH)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (pop && (cnt_q != '0)) begin
        ptr_q <= ptr_dec;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign top = (cnt_q == '0) ? '0 : mem[ptr_q];

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with exception/eret/redirect/halt next-PC selection.
// Latency: pc_next is combinational; pc_out follows one cycle later.
// Backpressure: stall=1 or ihit=0 holds the PC; redirect and exception override the hold.
// Ports: CLK, RST (sync, active-high) plain; everything else through pc_unit_if.pc.
// Optional macro PC_RAS_EN adds the return-address stack (pc_ras) and RAS_DEPTH.
module pc_unit
  import cpu_types_pkg::*;
#(
  parameter int                WORD_W     = 32,
  parameter logic [WORD_W-1:0] RESET_PC   = WORD_W'(PC_RESET_DEFAULT),
  parameter int                PC_STEP    = PC_STEP_DEFAULT,
  parameter logic [WORD_W-1:0] EXC_VECTOR = WORD_W'(EXC_VECTOR_DEFAULT)
`ifdef PC_RAS_EN
  , parameter int              RAS_DEPTH  = 4
`endif
) (
  input logic     CLK,
  input logic     RST,
  pc_unit_if.pc   bus
);

  pc_state_t         state_q, state_nxt;
  logic [WORD_W-1:0] pc_q, pc_nxt;
  logic [WORD_W-1:0] epc_q, epc_nxt;
  logic              mis_q, mis_nxt;
  logic [WORD_W-1:0] seq_pc;

  // Wraps naturally modulo 2^WORD_W.
  assign seq_pc = pc_q + WORD_W'(PC_STEP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
      mis_q   <= mis_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    mis_nxt   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.exc_req) begin
          pc_nxt  = EXC_VECTOR;
          epc_nxt = bus.exc_pc;
        end else if (bus.eret) begin
          pc_nxt = epc_q;
        end else if (bus.redir_valid) begin
          // A flush wins over stall; low bits are dropped and flagged.
          pc_nxt  = {bus.redir_target[WORD_W-1:2], 2'b00};
          mis_nxt = |bus.redir_target[1:0];
        end else if (bus.ihit && !bus.stall) begin
          pc_nxt = seq_pc;
        end
        // The PC update above still lands on the halting edge.
        if (bus.halt) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  assign bus.pc_out   = pc_q;
  assign bus.pc_next  = pc_nxt;
  assign bus.epc_out  = epc_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.misalign = mis_q;

`ifdef PC_RAS_EN
  logic ras_en;

  assign ras_en = !bus.stall && (state_q == RUN);

  pc_ras #(
    .WORD_W (WORD_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk      (CLK),
    .rst      (RST),
    .en       (ras_en),
    .push     (bus.ras_push),
    .pop      (bus.ras_pop),
    .push_dat (seq_pc),
    .top      (bus.ras_top)
  );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: reference model feeds a scoreboard queue,
// outputs are compared one cycle after each stimulus cycle.
module tb_pc_unit;
  import cpu_types_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0400;
  localparam logic [31:0] EXC_V  = 32'h8000_0180;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_unit_if #(.WORD_W(32)) bus ();

  pc_unit #(
    .WORD_W     (32),
    .RESET_PC   (RST_PC),
    .PC_STEP    (4),
    .EXC_VECTOR (EXC_V)
`ifdef PC_RAS_EN
    , .RAS_DEPTH (4)
`endif
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        halted;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: drive, predict, queue the prediction, then compare.
  task automatic cyc(input logic r, input logic ih, input logic st, input logic rv,
                     input logic [31:0] tgt, input logic ex, input logic [31:0] epc,
                     input logic er, input logic hl);
    exp_t        e;
    logic [31:0] nxt;
    rst              = r;
    bus.ihit         = ih;
    bus.stall        = st;
    bus.redir_valid  = rv;
    bus.redir_target = tgt;
    bus.exc_req      = ex;
    bus.exc_pc       = epc;
    bus.eret         = er;
    bus.halt         = hl;
    e.mis = 1'b0;
    nxt   = m_pc;
    if (r) begin
      nxt      = RST_PC;
      m_epc    = 32'h0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (ex) begin
        nxt   = EXC_V;
        m_epc = epc;
      end else if (er) begin
        nxt = m_epc;
      end else if (rv) begin
        nxt   = tgt & 32'hFFFF_FFFC;
        e.mis = (tgt[1:0] != 2'b00);
      end else if (ih && !st) begin
        nxt = m_pc + 32'd4;
      end
      m_halted = hl;
    end
    #1;
    if (!r) check("pc_next", bus.pc_next, nxt);
    m_pc     = nxt;
    e.pc     = nxt;
    e.epc    = m_epc;
    e.halted = m_halted;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("pc_out", bus.pc_out, e.pc);
    check("epc_out", bus.epc_out, e.epc);
    check("halted", {31'b0, bus.halted}, {31'b0, e.halted});
    check("misalign", {31'b0, bus.misalign}, {31'b0, e.mis});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic r, ih, st, rv, ex, er, hl;
    rst = 1'b1;
    bus.ihit = 0; bus.stall = 0; bus.redir_valid = 0; bus.redir_target = 0;
    bus.exc_req = 0; bus.exc_pc = 0; bus.eret = 0; bus.halt = 0;
`ifdef PC_RAS_EN
    bus.ras_push = 0; bus.ras_pop = 0;
`endif
    m_pc = RST_PC; m_epc = 0; m_halted = 0;
    @(posedge clk); #1;

    // Reset and sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h7777, 1, 32'h99, 1, 1);
    check("rst_pc", bus.pc_out, 32'h400);
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("seq3", bus.pc_out, 32'h40C);

    // Hold and flush over stall
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    check("hold", bus.pc_out, 32'h40C);
    cyc(0, 1, 1, 1, 32'h1002, 0, 0, 0, 0);
    check("flush", bus.pc_out, 32'h1000);
    check("mis_pulse", {31'b0, bus.misalign}, 32'd1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("mis_clr", {31'b0, bus.misalign}, 32'd0);

    // Exception and return
    cyc(0, 0, 1, 0, 0, 1, 32'h2040, 0, 0);
    check("exc_vec", bus.pc_out, 32'h8000_0180);
    check("exc_epc", bus.epc_out, 32'h2040);
    repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
    check("eret", bus.pc_out, 32'h2040);
    cyc(0, 1, 0, 1, 32'h5000, 1, 32'h3000, 1, 0);
    check("exc_over_eret", bus.epc_out, 32'h3000);

    // Wrap-around
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap", bus.pc_out, 32'h0);

    // Halt freezes everything until reset
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 32'h500, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 32'h600, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 1, 0);
    check("frozen", bus.pc_out, 32'h4);
    check("halted", {31'b0, bus.halted}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_from_halt", bus.pc_out, 32'h400);

    // Halt together with an exception
    cyc(0, 1, 0, 0, 0, 1, 32'h44, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    check("halt_exc", bus.pc_out, 32'h8000_0180);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random mix against the model
    for (int i = 0; i < 80; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      ih = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 3) == 0);
      ex = ($urandom_range(0, 7) == 0);
      er = ($urandom_range(0, 7) == 0);
      hl = ($urandom_range(0, 31) == 0);
      cyc(r, ih, st, rv, $urandom, ex, $urandom, er, hl);
    end

`ifdef PC_RAS_EN
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ras_rst", bus.ras_top, 32'h0);
    cyc(0, 0, 0, 1, 32'h10, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      bus.ras_push = 1;
      cyc(0, 0, 0, 1, (k + 1) * 32'h10, 0, 0, 0, 0);
    end
    bus.ras_push = 0;
    check("ras_full", bus.ras_top, 32'h54);
    bus.ras_pop = 1;
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    bus.ras_pop = 0;
    check("ras_stall", bus.ras_top, 32'h54);
    begin
      logic [31:0] pop_exp [5];
      pop_exp[0] = 32'h44; pop_exp[1] = 32'h34; pop_exp[2] = 32'h24;
      pop_exp[3] = 32'h0;  pop_exp[4] = 32'h0;
      for (int k = 0; k < 5; k++) begin
        bus.ras_pop = 1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ras_pop = 0;
        check("ras_pop", bus.ras_top, pop_exp[k]);
      end
    end
    bus.ras_push = 1;
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.ras_push = 0;
    check("ras_pre_rst", bus.ras_top, 32'h64);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("ras_mid_rst", bus.ras_top, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
